dual_port_mem_ctrl: RTL and testbench

DUAL_PORT_MEM_CTRL -- requirements
Module: dual_port_mem_ctrl

---
 rtl/dual_port_mem_ctrl_if.sv | 52 +++++
 rtl/dual_port_mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_dual_port_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_mem_ctrl_if
// Description : Request/response bundle for dual_port_mem_ctrl. It carries an
//               instruction-fetch port (i_*) and a data load/store port (d_*).
//               The master modport belongs to the requester and the slave
//               modport belongs to the controller.
//   i_req_valid/i_req_ready/i_req_addr      fetch request handshake
//   i_resp_valid/i_resp_data/i_resp_exc     fetch response (no back-pressure)
//   d_req_valid/d_req_ready/d_req_wren      data request handshake, 1 = write
//   d_req_mask/d_req_addr/d_req_wdata       byte enables, address, write data
//   d_resp_valid/d_resp_data/d_resp_exc     data response (reads and writes)
// Revision    : 1.0 - initial release
// ============================================================================
interface dual_port_mem_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_resp_valid;
    logic [DATA_W-1:0] i_resp_data;
    logic              i_resp_exc;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_req_wren;
    logic [MASK_W-1:0] d_req_mask;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic              d_resp_exc;

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data, i_resp_exc,
        output d_req_valid, d_req_wren, d_req_mask, d_req_addr, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data, d_resp_exc
    );

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data, i_resp_exc,
        input  d_req_valid, d_req_wren, d_req_mask, d_req_addr, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data, d_resp_exc
    );
endinterface
`default_nettype wire

// File: rtl/dual_port_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_mem_ctrl
// Description : A single-ported DEPTH x DATA_W memory that is shared between an
//               instruction-fetch port and a data port. The data port has fixed
//               priority. A starvation counter gives the fetch port a forced
//               grant. Every accepted request enters a LATENCY-deep pipeline
//               that is tagged with its source port. Out-of-range and misaligned
//               addresses return exc=1 and data 0.
// Ports       : CLK, RESET (sync, active-high), bus (dual_port_mem_ctrl_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_mem_ctrl #(
    parameter int                DATA_W       = 64,
    parameter int                ADDR_W       = 64,
    parameter int                DEPTH        = 1024,
    parameter int                LATENCY      = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(64'h8000_0000),
    parameter int                STARVE_LIMIT = 4
) (
    input  wire logic           CLK,
    input  wire logic           RESET,
    dual_port_mem_ctrl_if.slave bus
);
    // MASK_W must agree with the interface instance (same DATA_W).
    localparam int MASK_W  = DATA_W / 8;
    localparam int c_ofs_w = $clog2(MASK_W);
    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cnt_w = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [c_cnt_w-1:0] r_starve;
    logic               w_force;
    logic               w_acc_i;
    logic               w_acc_d;
    logic               w_acc;
    logic               w_wr;
    logic               w_fault;
    logic [ADDR_W-1:0]  w_addr;
    logic [ADDR_W-1:0]  w_off;
    logic [ADDR_W-1:0]  w_word;
    logic [c_idx_w-1:0] w_idx;
    logic               w_out_v;

    logic [DATA_W-1:0]  r_mem  [DEPTH];
    logic [DATA_W-1:0]  r_data [LATENCY];
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_is_i;
    logic [LATENCY-1:0] r_exc;
    logic [LATENCY-1:0] r_is_wr;

    // ------------------------------------------------------------------
    // Arbitration and address decode. The two ready terms are mutually
    // exclusive whenever both valids are high, so at most one request
    // reaches the array in any cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_force         = bus.i_req_valid && (r_starve == c_cnt_w'(STARVE_LIMIT));
        bus.d_req_ready = !RESET && !w_force;
        bus.i_req_ready = !RESET && (!bus.d_req_valid || w_force);
        w_acc_i         = bus.i_req_valid && bus.i_req_ready;
        w_acc_d         = bus.d_req_valid && bus.d_req_ready;
        w_acc           = w_acc_i || w_acc_d;

        w_addr  = w_acc_i ? bus.i_req_addr : bus.d_req_addr;
        w_off   = w_addr - BASE_ADDR;
        w_word  = w_off >> c_ofs_w;
        w_idx   = w_word[c_idx_w-1:0];
        // When addr < BASE_ADDR the subtraction wraps. That term is checked
        // explicitly so the fault does not depend on the wrapped value.
        w_fault = (w_addr < BASE_ADDR)
               || (w_word >= ADDR_W'(DEPTH))
               || ((w_addr & ADDR_W'(MASK_W - 1)) != '0);
        w_wr    = w_acc_d && bus.d_req_wren && !w_fault;
    end

    // The counter counts cycles in which a fetch is waiting and is not granted.
    // Once it reaches STARVE_LIMIT the fetch is granted, so it never passes
    // the limit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_starve <= '0;
        end else if (bus.i_req_valid && !w_acc_i) begin
            r_starve <= r_starve + c_cnt_w'(1);
        end else begin
            r_starve <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Array and data pipeline. There is no reset here, so the contents
    // survive RESET. A read in the same cycle sees the contents as they
    // were before this edge. Because only one access happens per cycle, a
    // read always sees every write accepted at an earlier edge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (bus.d_req_mask[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= bus.d_req_wdata[b*8 +: 8];
                end
            end
        end
        if (w_acc) begin
            r_data[0] <= r_mem[w_idx];
        end
        for (int k = 1; k < LATENCY; k++) begin
            r_data[k] <= r_data[k-1];
        end
    end

    // Only the valid bits need a reset. The tag bits are don't-care while
    // their stage is empty.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_acc;
            for (int k = 1; k < LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        r_is_i[0]  <= w_acc_i;
        r_exc[0]   <= w_fault;
        r_is_wr[0] <= w_acc_d && bus.d_req_wren;
        for (int k = 1; k < LATENCY; k++) begin
            r_is_i[k]  <= r_is_i[k-1];
            r_exc[k]   <= r_exc[k-1];
            r_is_wr[k] <= r_is_wr[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Response outputs. The response is routed by the port tag. The data
    // is forced to 0 for idle slots, faults and writes. While RESET is
    // high the outputs are gated off, so a request that is being
    // discarded is never seen.
    // ------------------------------------------------------------------
    always_comb begin
        w_out_v          = r_vld[LATENCY-1] && !RESET;
        bus.i_resp_valid = w_out_v && r_is_i[LATENCY-1];
        bus.d_resp_valid = w_out_v && !r_is_i[LATENCY-1];
        bus.i_resp_exc   = bus.i_resp_valid && r_exc[LATENCY-1];
        bus.d_resp_exc   = bus.d_resp_valid && r_exc[LATENCY-1];
        bus.i_resp_data  = (bus.i_resp_valid && !r_exc[LATENCY-1])
                           ? r_data[LATENCY-1] : '0;
        bus.d_resp_data  = (bus.d_resp_valid && !r_exc[LATENCY-1] && !r_is_wr[LATENCY-1])
                           ? r_data[LATENCY-1] : '0;
    end
endmodule
`default_nettype wire

// File: tb/tb_dual_port_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_mem_ctrl
// Description : Self-checking bench for dual_port_mem_ctrl. A byte-level memory
//               model predicts every response when its request is accepted.
//               The prediction is queued per port and popped when it is due.
//               Directed steps cover arbitration, faults and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_mem_ctrl;
    localparam logic [63:0] c_BASE = 64'h8000_0000;
    localparam int          c_LAT  = 2;

    typedef struct {
        int          due;
        logic [63:0] data;
        logic        exc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_port_mem_ctrl_if #(.DATA_W(64), .ADDR_W(64)) bus ();

    dual_port_mem_ctrl #(
        .DATA_W      (64),
        .ADDR_W      (64),
        .DEPTH       (1024),
        .LATENCY     (c_LAT),
        .BASE_ADDR   (64'h8000_0000),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          ncyc   = 0;
    exp_t        iq[$];
    exp_t        dq[$];
    logic [63:0] model[longint];
    logic [63:0] last_d = '0;
    logic [63:0] last_i = '0;
    logic        last_d_exc = 1'b0;
    logic        last_i_exc = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [63:0] a);
        logic [63:0] w;
        w = (a - c_BASE) >> 3;
        return (a < c_BASE) || (w >= 64'd1024) || (a[2:0] != 3'b000);
    endfunction

    // Apply the request to the model and return the response it should produce.
    function automatic exp_t predict(input logic wr, input logic [7:0] m,
                                     input logic [63:0] a, input logic [63:0] wd);
        exp_t        e;
        longint      idx;
        logic [63:0] cur;
        e.due  = ncyc + c_LAT;
        e.data = '0;
        e.exc  = 1'b0;
        if (is_fault(a)) begin
            e.exc = 1'b1;
            return e;
        end
        idx = longint'((a - c_BASE) >> 3);
        cur = model.exists(idx) ? model[idx] : 64'h0;
        if (wr) begin
            for (int b = 0; b < 8; b++) begin
                if (m[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
            end
            model[idx] = cur;
        end else begin
            e.data = cur;
        end
        return e;
    endfunction

    // Monitor: on each falling edge, check the responses and record the accepts.
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        ncyc++;
        if (rst) begin
            check("rst_i_resp_valid", bus.i_resp_valid, 0);
            check("rst_d_resp_valid", bus.d_resp_valid, 0);
            check("rst_d_resp_data", bus.d_resp_data, 0);
            iq.delete();
            dq.delete();
        end else begin
            exp_v = (iq.size() > 0) && (iq[0].due == ncyc);
            check("i_resp_valid", bus.i_resp_valid, exp_v);
            if (exp_v) begin
                e = iq.pop_front();
                if (bus.i_resp_valid) begin
                    check("i_resp_data", bus.i_resp_data, e.data);
                    check("i_resp_exc", bus.i_resp_exc, e.exc);
                    last_i     = bus.i_resp_data;
                    last_i_exc = bus.i_resp_exc;
                end
            end
            exp_v = (dq.size() > 0) && (dq[0].due == ncyc);
            check("d_resp_valid", bus.d_resp_valid, exp_v);
            if (exp_v) begin
                e = dq.pop_front();
                if (bus.d_resp_valid) begin
                    check("d_resp_data", bus.d_resp_data, e.data);
                    check("d_resp_exc", bus.d_resp_exc, e.exc);
                    last_d     = bus.d_resp_data;
                    last_d_exc = bus.d_resp_exc;
                end
            end
        end
        if (bus.i_req_valid && bus.i_req_ready)
            iq.push_back(predict(1'b0, 8'h00, bus.i_req_addr, 64'h0));
        if (bus.d_req_valid && bus.d_req_ready)
            dq.push_back(predict(bus.d_req_wren, bus.d_req_mask, bus.d_req_addr, bus.d_req_wdata));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.d_req_valid = 1'b0;
        bus.d_req_wren  = 1'b0;
        bus.d_req_mask  = '0;
        bus.d_req_addr  = '0;
        bus.d_req_wdata = '0;
    endtask

    task automatic d_req(input logic wr, input logic [7:0] m, input logic [63:0] a,
                         input logic [63:0] wd);
        bus.d_req_valid = 1'b1;
        bus.d_req_wren  = wr;
        bus.d_req_mask  = m;
        bus.d_req_addr  = a;
        bus.d_req_wdata = wd;
    endtask

    task automatic i_req(input logic [63:0] a);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = a;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.i_req_valid = 1'b1;
        bus.d_req_valid = 1'b1;
        cyc();
        cyc();
        check("rst_i_req_ready", bus.i_req_ready, 0);
        check("rst_d_req_ready", bus.d_req_ready, 0);
        check("rst_i_resp_data", bus.i_resp_data, 0);
        check("rst_i_resp_exc", bus.i_resp_exc, 0);
        idle();
        rst = 1'b0;
        cyc();

        // Full write, then a read of the same word one cycle later.
        d_req(1'b1, 8'hFF, c_BASE + 64'h10, 64'h1122_3344_5566_7788); cyc();
        d_req(1'b0, 8'h00, c_BASE + 64'h10, 64'h0);                   cyc();
        idle(); repeat (3) cyc();
        check("full_write_read", last_d, 64'h1122_3344_5566_7788);
        check("full_write_exc", last_d_exc, 0);

        // Partial write over the same word.
        d_req(1'b1, 8'h0F, c_BASE + 64'h10, 64'hAAAA_AAAA_BBBB_BBBB); cyc();
        d_req(1'b0, 8'h00, c_BASE + 64'h10, 64'h0);                   cyc();
        idle(); repeat (3) cyc();
        check("partial_write_read", last_d, 64'h1122_3344_BBBB_BBBB);

        // An all-zero mask write is legal and changes nothing.
        d_req(1'b1, 8'h00, c_BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF); cyc();
        d_req(1'b0, 8'h00, c_BASE + 64'h10, 64'h0);                   cyc();
        idle(); repeat (3) cyc();
        check("zero_mask_read", last_d, 64'h1122_3344_BBBB_BBBB);

        // Faults: out of range and misaligned; faulting writes must not land.
        d_req(1'b1, 8'hFF, c_BASE, 64'h0123_4567_89AB_CDEF); cyc();
        d_req(1'b0, 8'h00, c_BASE + 64'h2000, 64'h0);        cyc();
        idle(); repeat (3) cyc();
        check("oor_exc", last_d_exc, 1);
        check("oor_data", last_d, 0);
        d_req(1'b0, 8'h00, c_BASE + 64'h10, 64'h0); cyc();
        d_req(1'b0, 8'h00, c_BASE + 64'h4, 64'h0);  cyc();
        idle(); repeat (3) cyc();
        check("misaligned_exc", last_d_exc, 1);
        check("misaligned_data", last_d, 0);
        d_req(1'b1, 8'hFF, c_BASE + 64'h4, 64'hDEAD_BEEF_DEAD_BEEF);    cyc();
        d_req(1'b1, 8'hFF, c_BASE - 64'h8, 64'hDEAD_BEEF_DEAD_BEEF);    cyc();
        d_req(1'b1, 8'hFF, c_BASE + 64'h2000, 64'hDEAD_BEEF_DEAD_BEEF); cyc();
        d_req(1'b0, 8'h00, c_BASE, 64'h0);                              cyc();
        idle(); repeat (3) cyc();
        check("fault_write_no_effect", last_d, 64'h0123_4567_89AB_CDEF);
        i_req(c_BASE + 64'h2000); cyc();
        idle(); repeat (3) cyc();
        check("i_oor_exc", last_i_exc, 1);

        // Both ports requesting continuously: data wins 4 cycles, then instr.
        i_req(c_BASE);
        d_req(1'b0, 8'h00, c_BASE + 64'h10, 64'h0);
        for (int k = 0; k < 15; k++) begin
            #1;
            check("arb_i_ready", bus.i_req_ready, (k % 5) == 4);
            check("arb_d_ready", bus.d_req_ready, (k % 5) != 4);
            cyc();
        end
        idle(); repeat (3) cyc();
        check("arb_last_i", last_i, 64'h0123_4567_89AB_CDEF);

        // Alternating lone requests: each accepted, one response per cycle.
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k % 2 == 0) i_req(c_BASE + 64'h10);
            else            d_req(1'b0, 8'h00, c_BASE, 64'h0);
            #1;
            if (k % 2 == 0) check("alt_i_ready", bus.i_req_ready, 1);
            else            check("alt_d_ready", bus.d_req_ready, 1);
            cyc();
        end
        idle(); repeat (3) cyc();
        check("alt_last_i", last_i, 64'h1122_3344_BBBB_BBBB);

        // Reset one cycle after two reads are accepted: neither read is answered.
        d_req(1'b1, 8'hFF, c_BASE + 64'h20, 64'hCAFE_F00D_1234_5678); cyc();
        idle(); repeat (3) cyc();
        d_req(1'b0, 8'h00, c_BASE + 64'h20, 64'h0); cyc();
        idle();
        i_req(c_BASE + 64'h20);                     cyc();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        check("post_rst_last_d_untouched", last_d, 64'h0);
        d_req(1'b0, 8'h00, c_BASE + 64'h20, 64'h0); cyc();
        idle(); repeat (3) cyc();
        check("post_rst_read", last_d, 64'hCAFE_F00D_1234_5678);

        repeat (3) cyc();
        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
